oam_dma_controller: RTL and testbench

- Sequences the memory router's DMA read and write ports to perform the GBC OAM DMA transfer.
- A CPU write to the DMA register (0xFF46) starts a copy of DMA_LEN bytes from {src_hi, 0x00} to DST_BASE.
- Each byte is read through the RDMA port and written through the WDMA port.
- O_DMA_ACTIVE tells the CPU/PPU side that OAM is owned by DMA.

---
 rtl/oam_dma_controller.sv | 146 ++++++++++++++
 tb/tb_oam_dma_controller.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma_controller.sv
// oam_dma_controller
// Copies DMA_LEN bytes from the page written to DMA_REG_ADDR into OAM
// (DST_BASE) through the memory router's DMA read/write ports. Each byte
// takes three cycles: READ (address out), CAPTURE (router data returns and is
// latched), WRITE (byte written to OAM).
//
// Ports:
//   I_CLK, I_RESET                  clock, asynchronous active-high reset
//   I_IOREG_ADDR/DATA/WE_L          CPU IO register write bus (trigger)
//   O_DMA_SRC_HI                    readback of the last value written to the DMA register
//   O_RDMA_ADDR, I_RDMA_DATA,
//   O_RDMA_RE_L                     router read port (active-low enable)
//   O_WDMA_ADDR, O_WDMA_DATA,
//   O_WDMA_WE_L                     router write port (active-low enable)
//   O_DMA_ACTIVE                    OAM is owned by the DMA engine
//   O_DMA_DONE                      one-cycle pulse after the last byte is written
module oam_dma_controller #(
    parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
    parameter int          DMA_LEN      = 160,
    parameter logic [15:0] DST_BASE     = 16'hFE00,
    parameter int          START_DELAY  = 1
) (
    input  logic        I_CLK,
    input  logic        I_RESET,
    input  logic [15:0] I_IOREG_ADDR,
    input  logic [7:0]  I_IOREG_DATA,
    input  logic        I_IOREG_WE_L,
    output logic [7:0]  O_DMA_SRC_HI,
    output logic [15:0] O_RDMA_ADDR,
    input  logic [7:0]  I_RDMA_DATA,
    output logic        O_RDMA_RE_L,
    output logic [15:0] O_WDMA_ADDR,
    output logic [7:0]  O_WDMA_DATA,
    output logic        O_WDMA_WE_L,
    output logic        O_DMA_ACTIVE,
    output logic        O_DMA_DONE
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        READ,
        CAPTURE,
        WRITE,
        DONE
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);
    localparam logic [3:0] DLY_LAST = (START_DELAY > 0) ? 4'(START_DELAY - 1) : 4'd0;

    state_t     state, state_nxt;
    logic [7:0] idx, idx_nxt;
    logic [3:0] dly, dly_nxt;
    logic [7:0] page;
    logic [7:0] src_hi;
    logic [7:0] data_lat;
    logic       trigger;

    assign trigger = !I_IOREG_WE_L && (I_IOREG_ADDR == DMA_REG_ADDR);

    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            state    <= IDLE;
            idx      <= 8'h00;
            dly      <= 4'h0;
            page     <= 8'h00;
            src_hi   <= 8'h00;
            data_lat <= 8'h00;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            dly   <= dly_nxt;
            if (trigger) begin
                src_hi <= I_IOREG_DATA;
                // Echo RAM (0xE000-0xFDFF) mirrors WRAM 0x2000 lower.
                page   <= (I_IOREG_DATA >= 8'hE0) ? (I_IOREG_DATA - 8'h20) : I_IOREG_DATA;
            end
            // Router data for the READ-cycle address is valid during CAPTURE.
            if (state == CAPTURE) begin
                data_lat <= I_RDMA_DATA;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        dly_nxt   = dly;
        case (state)
            IDLE: ;
            SETUP: begin
                if (dly == DLY_LAST) begin
                    state_nxt = READ;
                    dly_nxt   = 4'h0;
                end else begin
                    dly_nxt = dly + 4'h1;
                end
            end
            READ:    state_nxt = CAPTURE;
            CAPTURE: state_nxt = WRITE;
            WRITE: begin
                if (idx == LAST_IDX) begin
                    state_nxt = DONE;
                end else begin
                    idx_nxt   = idx + 8'h01;
                    state_nxt = READ;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // A trigger restarts from any state; a WRITE in flight still completes
        // because its strobe is decoded from the current (registered) state.
        if (trigger) begin
            state_nxt = (START_DELAY > 0) ? SETUP : READ;
            idx_nxt   = 8'h00;
            dly_nxt   = 4'h0;
        end
    end

    // Moore outputs decoded from the registered state only.
    always_comb begin
        O_RDMA_RE_L  = 1'b1;
        O_RDMA_ADDR  = 16'h0000;
        O_WDMA_WE_L  = 1'b1;
        O_WDMA_ADDR  = 16'h0000;
        O_WDMA_DATA  = 8'h00;
        O_DMA_DONE   = 1'b0;
        O_DMA_ACTIVE = (state != IDLE);
        O_DMA_SRC_HI = src_hi;
        case (state)
            READ, CAPTURE: begin
                O_RDMA_RE_L = 1'b0;
                O_RDMA_ADDR = {page, idx};
            end
            WRITE: begin
                O_WDMA_WE_L = 1'b0;
                O_WDMA_ADDR = DST_BASE + {8'h00, idx};
                O_WDMA_DATA = data_lat;
            end
            DONE:    O_DMA_DONE = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_oam_dma_controller.sv
// Directed bench for oam_dma_controller with default parameters.
// Models the router: read data returns one cycle after a RE_L-low address,
// writes into an OAM array (0xFE00..0xFEFF) on WE_L-low edges.
module tb_oam_dma_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] io_addr;
    logic [7:0]  io_data;
    logic        io_we_l;
    logic [7:0]  src_hi;
    logic [15:0] rd_addr;
    logic [7:0]  rd_data;
    logic        rd_re_l;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_we_l;
    logic        active;
    logic        done;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0]  wram [0:65535];
    logic [7:0]  oam  [0:255];
    logic        clr_oam = 1'b0;
    int          wr_cnt = 0;
    int          done_cnt = 0;
    int          overlap_cnt = 0;
    logic [15:0] last_rd = 16'h0;

    always #5 clk = ~clk;

    oam_dma_controller dut (
        .I_CLK        (clk),
        .I_RESET      (rst),
        .I_IOREG_ADDR (io_addr),
        .I_IOREG_DATA (io_data),
        .I_IOREG_WE_L (io_we_l),
        .O_DMA_SRC_HI (src_hi),
        .O_RDMA_ADDR  (rd_addr),
        .I_RDMA_DATA  (rd_data),
        .O_RDMA_RE_L  (rd_re_l),
        .O_WDMA_ADDR  (wr_addr),
        .O_WDMA_DATA  (wr_data),
        .O_WDMA_WE_L  (wr_we_l),
        .O_DMA_ACTIVE (active),
        .O_DMA_DONE   (done)
    );

    // Router model and bus monitors
    always @(posedge clk) begin
        if (!rd_re_l) begin
            rd_data <= wram[rd_addr];
            last_rd <= rd_addr;
        end
        if (clr_oam) begin
            for (int i = 0; i < 256; i++) oam[i] <= 8'hEE;
        end else if (!wr_we_l && wr_addr[15:8] == 8'hFE) begin
            oam[wr_addr[7:0]] <= wr_data;
        end
        if (!wr_we_l) wr_cnt <= wr_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (!rd_re_l && !wr_we_l) overlap_cnt <= overlap_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one IO write; returns #1 after the edge that samples it (cycle 1).
    task automatic io_write(input logic [15:0] a, input logic [7:0] d);
        io_addr = a;
        io_data = d;
        io_we_l = 1'b0;
        @(posedge clk);
        #1;
        io_we_l = 1'b1;
        io_addr = 16'h0000;
    endtask

    task automatic clear_oam();
        clr_oam = 1'b1;
        tick(1);
        clr_oam = 1'b0;
    endtask

    // Called in cycle 1 after a trigger; returns the cycle index in which DONE
    // was seen and the number of cycles ACTIVE was high up to and including it.
    task automatic wait_done(output int cyc, output int act);
        cyc = 1;
        act = 0;
        while (!done && cyc < 1000) begin
            if (active) act++;
            tick(1);
            cyc++;
        end
        if (active) act++;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_re_l"},   rd_re_l, 1'b1);
        chk({tag, "_we_l"},   wr_we_l, 1'b1);
        chk({tag, "_rdaddr"}, rd_addr, 16'h0000);
        chk({tag, "_wraddr"}, wr_addr, 16'h0000);
        chk({tag, "_wrdata"}, wr_data, 8'h00);
        chk({tag, "_active"}, active, 1'b0);
        chk({tag, "_done"},   done, 1'b0);
        chk({tag, "_srchi"},  src_hi, 8'h00);
    endtask

    initial begin
        int cyc, act, errs, w0, d0;
        for (int i = 0; i < 65536; i++) wram[i] = 8'h00;
        for (int i = 0; i < 256; i++) begin
            wram[16'hC000 + i] = 8'(i);
            wram[16'hD000 + i] = 8'(i) ^ 8'h5A;
            wram[16'hD100 + i] = 8'hFF - 8'(i);
        end
        io_addr = 16'h0000;
        io_data = 8'h00;
        io_we_l = 1'b1;
        rst     = 1'b1;
        tick(3);
        chk_reset_outputs("reset");
        rst = 1'b0;
        clear_oam();

        // Basic transfer from page 0xC0
        io_write(16'hFF46, 8'hC0);
        chk("c0_active_c1", active, 1'b1);
        chk("c0_srchi", src_hi, 8'hC0);
        d0 = done_cnt;
        wait_done(cyc, act);
        chk("c0_done_cycle", cyc, 482);
        chk("c0_active_cycles", act, 482);
        tick(1);
        chk("c0_active_after", active, 1'b0);
        chk("c0_done_after", done, 1'b0);
        errs = 0;
        for (int i = 0; i < 160; i++) if (oam[i] !== 8'(i)) errs++;
        chk("c0_oam_errs", errs, 0);
        chk("c0_oam_untouched", oam[160], 8'hEE);
        chk("c0_done_count", done_cnt - d0, 1);

        // Cycle-accurate view of byte 5: cycles 17,18 read, 19 write
        io_write(16'hFF46, 8'hC0);
        tick(15);
        chk("b5_c16_re_l", rd_re_l, 1'b1);
        tick(1);
        chk("b5_c17_re_l", rd_re_l, 1'b0);
        chk("b5_c17_addr", rd_addr, 16'hC005);
        chk("b5_c17_we_l", wr_we_l, 1'b1);
        tick(1);
        chk("b5_c18_re_l", rd_re_l, 1'b0);
        chk("b5_c18_addr", rd_addr, 16'hC005);
        chk("b5_c18_we_l", wr_we_l, 1'b1);
        tick(1);
        chk("b5_c19_re_l", rd_re_l, 1'b1);
        chk("b5_c19_we_l", wr_we_l, 1'b0);
        chk("b5_c19_waddr", wr_addr, 16'hFE05);
        chk("b5_c19_wdata", wr_data, 8'h05);
        wait_done(cyc, act);
        chk("b5_done_cycle", cyc, 482 - 18);

        // Echo page 0xF1 folds to 0xD1
        clear_oam();
        io_write(16'hFF46, 8'hF1);
        chk("echo_srchi", src_hi, 8'hF1);
        tick(1);
        chk("echo_first_rd", rd_addr, 16'hD100);
        wait_done(cyc, act);
        chk("echo_done_cycle", cyc, 482 - 1);
        chk("echo_last_rd", last_rd, 16'hD19F);
        errs = 0;
        for (int i = 0; i < 160; i++) if (oam[i] !== 8'hFF - 8'(i)) errs++;
        chk("echo_oam_errs", errs, 0);

        // Retrigger with 0xD0 while reading byte 30 of a 0xC0 transfer
        clear_oam();
        d0 = done_cnt;
        io_write(16'hFF46, 8'hC0);
        tick(91);
        chk("rt_c92_addr", rd_addr, 16'hC01E);
        io_write(16'hFF46, 8'hD0);
        chk("rt_srchi", src_hi, 8'hD0);
        wait_done(cyc, act);
        chk("rt_done_cycle", cyc, 482);
        tick(2);
        chk("rt_done_count", done_cnt - d0, 1);
        errs = 0;
        for (int i = 0; i < 160; i++) if (oam[i] !== (8'(i) ^ 8'h5A)) errs++;
        chk("rt_oam_errs", errs, 0);

        // Reset during CAPTURE of byte 50 (cycle 153)
        clear_oam();
        io_write(16'hFF46, 8'hC0);
        tick(152);
        chk("rst_capture_re_l", rd_re_l, 1'b0);
        chk("rst_capture_addr", rd_addr, 16'hC032);
        w0 = wr_cnt;
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outputs("rst_mid");
        tick(3);
        rst = 1'b0;
        tick(4);
        chk("rst_no_write", wr_cnt - w0, 0);
        chk("rst_oam49", oam[49], 8'h31);
        chk("rst_oam50", oam[50], 8'hEE);
        io_write(16'hFF46, 8'hC0);
        wait_done(cyc, act);
        chk("rst_after_done_cycle", cyc, 482);
        errs = 0;
        for (int i = 0; i < 160; i++) if (oam[i] !== 8'(i)) errs++;
        chk("rst_after_oam_errs", errs, 0);
        tick(2);

        // Write to a neighbouring register is ignored
        io_write(16'hFF47, 8'h80);
        chk("ff47_active_c1", active, 1'b0);
        tick(3);
        chk("ff47_active", active, 1'b0);
        chk("ff47_re_l", rd_re_l, 1'b1);
        chk("ff47_srchi", src_hi, 8'hC0);

        chk("no_overlap", overlap_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
